adrv9001_rx_align: RTL and testbench
====================================

Name: adrv9001_rx_align

Overview:
Receive-path stage directly downstream of the ADRV9001 serdes packer. It consumes 16-bit packed I, Q and strobe words, finds the bit offset of the strobe frame boundary, and emits frame-aligned 16-bit I/Q samples. Lock, unlock and strobe-error status feed the AXI register space. Supported strobe formats: 8 bits on / 8 bits off, or 1 bit on / 15 bits off.

Parameters:
LOCK_COUNT, 4, consecutive strobe matches at the same offset needed to enter LOCKED (range 1..15)
UNLOCK_COUNT, 2, consecutive strobe mismatches in LOCKED needed to return to SEARCH (range 1..15)

Ports:
clk  in  1  main clock, same domain as the packer
rstn  in  1  synchronous active-low reset
strb_mode  in  1  0 = 8-on/8-off strobe (expected word 16'hFF00); 1 = 1-on/15-off strobe (expected word 16'h8000)
i_in  in  16  packed I word; bit 15 is the earliest serial bit
q_in  in  16  packed Q word
strb_in  in  16  packed strobe word
valid_in  in  1  input words valid (nominally every other cycle)
i_out  out  16  aligned I sample
q_out  out  16  aligned Q sample
valid_out  out  1  one-cycle pulse per aligned sample
locked  out  1  high in LOCKED state
offset  out  4  locked bit offset k
strb_err  out  1  one-cycle pulse on a strobe mismatch while LOCKED

Behaviour:
- Reset (rstn=0 at a clk edge): all outputs 0; previous-word registers 0; prev_ok=0; counters 0; state SEARCH; registered mode = strb_mode.
- All logic advances only on valid_in=1. Cycles with valid_in=0 hold all state; output pulses are 0.
- Window: w[31:0] = {prev_word, cur_word}, built per lane (I, Q, strobe). prev_ok is set by the first valid_in after reset or resync.
- Candidate at offset k (0..15): w[31-k:16-k]. match(k) = strobe candidate equals the expected pattern for the registered mode.
- No matching is done while prev_ok=0.
- SEARCH: choose the lowest k with match(k). If one exists, cand_k=k, cnt=1, go to VERIFY. If none, stay in SEARCH.
- VERIFY: if match(cand_k), cnt+1. When cnt reaches LOCK_COUNT, go to LOCKED and set offset=cand_k. If !match(cand_k), go to SEARCH with cnt=0. That same word is re-searched on the next valid_in, not the current one.
- LOCK_COUNT=1: go from SEARCH directly to LOCKED on the first match.
- LOCKED, per valid_in:
  - i_out/q_out = the I/Q candidates at offset; valid_out=1. Registered, so outputs appear 1 clk after the valid_in cycle.
  - On mismatch: strb_err=1 and errcnt+1. Data is still output.
  - On match: errcnt=0.
  - When errcnt reaches UNLOCK_COUNT: go to SEARCH, locked=0. valid_out stays 1 for that final word.
- locked is updated in the same clk as the state change.
- offset holds its last locked value while in SEARCH and VERIFY.
- Mode change: strb_mode is sampled every clk. A difference from the registered mode forces SEARCH, clears counters and prev_ok, and updates the registered mode, all within one clk, regardless of valid_in.
- Simultaneous reset and valid_in: reset wins.
- Simultaneous mode change and valid_in: the mode change wins; the word is stored as prev_word only.
- Only one of valid_out or strb_err can drive a state change per valid_in; no other events are pipelined.

Test Plan:
1. Mode 0, strobe words 16'h0FF0 repeated, LOCK_COUNT=4, I words alternating 16'h1234/16'h5678 → offset=4 (w[27:12]=FF00). locked rises on the 5th valid_in (1 prime + 4 matches). i_out = w[27:12] of the I window, e.g. 16'h2345. valid_out pulses once per valid_in after lock.
2. Mode 1, strobe words 16'h0001 repeated → offset=15 (w[16:1]=8000). locked after 5 valid_in. valid_out=0 throughout SEARCH/VERIFY.
3. Locked at offset 4 in mode 0; inject one strobe word 16'h0000 → strb_err pulses once, locked stays 1, errcnt clears on the next good word. Inject two consecutive bad words → locked=0 one clk after the second; the next valid_out is 0.
4. Locked; toggle strb_mode 0→1 with valid_in=0 → locked=0 on the next clk, prev_ok cleared. Then apply 16'h0001 words → relock at offset=15 after 5 valid_in.
5. Locked; pull rstn low for 1 clk concurrent with valid_in → all outputs 0 next clk, state SEARCH, offset=0.
6. valid_in gapped (1 high, 3 low), pattern as in scenario 1 → identical lock point counted in valid_in beats, and no output pulses on gap cycles.

Source files
------------

// File: rtl/adrv9001_rx_align.sv
// adrv9001_rx_align: finds the strobe frame bit offset in packed words and emits frame-aligned I/Q samples
module adrv9001_rx_align #(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        strb_mode,
  input  logic [15:0] i_in,
  input  logic [15:0] q_in,
  input  logic [15:0] strb_in,
  input  logic        valid_in,
  output logic [15:0] i_out,
  output logic [15:0] q_out,
  output logic        valid_out,
  output logic        locked,
  output logic [3:0]  offset,
  output logic        strb_err
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic [3:0] UC = 4'(UNLOCK_COUNT);

  // candidate at offset k is w[31-k:16-k] of {prev, cur}
  function automatic logic [15:0] f_cand(input logic [15:0] p, input logic [15:0] c, input logic [3:0] k);
    logic [31:0] s;
    s = {p, c} << k;
    return s[31:16];
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_mode, r_prev_ok, r_locked, r_valid, r_err;
  logic [15:0] r_prev_i, r_prev_q, r_prev_s, r_i, r_q;
  logic [3:0]  r_cnt, r_errcnt, r_cand, r_offset;
  logic [15:0] w_match, w_exp;
  logic [3:0]  w_k, w_sel, w_cnt_nxt, w_err_nxt;
  logic        w_found, w_hit, w_mode_chg, w_adv;

  assign w_exp      = r_mode ? 16'h8000 : 16'hFF00;
  assign w_mode_chg = strb_mode != r_mode;
  assign w_adv      = valid_in && r_prev_ok && !w_mode_chg;
  assign w_sel      = (r_state == LOCKED) ? r_offset : r_cand;
  assign w_hit      = w_match[w_sel];
  assign w_found    = |w_match;
  assign w_cnt_nxt  = r_cnt + 4'd1;
  assign w_err_nxt  = r_errcnt + 4'd1;

  for (genvar k = 0; k < 16; k++) begin : g_match
    assign w_match[k] = f_cand(r_prev_s, strb_in, 4'(k)) == w_exp;
  end

  // descending scan so the lowest matching offset wins
  always_comb begin
    w_k = '0;
    for (int j = 15; j >= 0; j--)
      if (w_match[j]) w_k = 4'(j);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_mode_chg) w_state_nxt = SEARCH;
    else if (w_adv)
      case (r_state)
        SEARCH:  w_state_nxt = !w_found ? SEARCH : (LC == 4'd1 ? LOCKED : VERIFY);
        VERIFY:  w_state_nxt = !w_hit ? SEARCH : (w_cnt_nxt == LC ? LOCKED : VERIFY);
        LOCKED:  w_state_nxt = (!w_hit && w_err_nxt == UC) ? SEARCH : LOCKED;
        default: w_state_nxt = SEARCH;
      endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= SEARCH;
      r_mode    <= strb_mode;
      r_prev_i  <= '0;
      r_prev_q  <= '0;
      r_prev_s  <= '0;
      r_prev_ok <= 1'b0;
      r_cnt     <= '0;
      r_errcnt  <= '0;
      r_cand    <= '0;
      r_offset  <= '0;
      r_locked  <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_i       <= '0;
      r_q       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (valid_in) begin
        r_prev_i <= i_in;
        r_prev_q <= q_in;
        r_prev_s <= strb_in;
      end
      if (w_mode_chg) begin
        r_mode    <= strb_mode;
        r_prev_ok <= 1'b0;
        r_cnt     <= '0;
        r_errcnt  <= '0;
        r_locked  <= 1'b0;
      end else if (valid_in) begin
        r_prev_ok <= 1'b1;
        if (r_prev_ok) begin
          r_locked <= w_state_nxt == LOCKED;
          if (r_state == SEARCH) begin
            r_cand <= w_k;
            r_cnt  <= w_found ? 4'd1 : 4'd0;
            if (w_state_nxt == LOCKED) r_offset <= w_k;
          end else if (r_state == VERIFY) begin
            r_cnt <= w_hit ? w_cnt_nxt : 4'd0;
            if (w_state_nxt == LOCKED) r_offset <= r_cand;
          end else begin
            r_valid  <= 1'b1;
            r_err    <= !w_hit;
            r_i      <= f_cand(r_prev_i, i_in, r_offset);
            r_q      <= f_cand(r_prev_q, q_in, r_offset);
            r_errcnt <= (w_hit || w_state_nxt == SEARCH) ? 4'd0 : w_err_nxt;
            if (w_state_nxt == SEARCH) r_cnt <= '0;
          end
        end
      end
    end
  end

  assign i_out     = r_i;
  assign q_out     = r_q;
  assign valid_out = r_valid;
  assign locked    = r_locked;
  assign offset    = r_offset;
  assign strb_err  = r_err;
endmodule

// File: tb/tb_adrv9001_rx_align.sv
// tb_adrv9001_rx_align: directed scenarios for strobe search, lock, error, mode change, reset and gapped input
module tb_adrv9001_rx_align;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        strb_mode = 1'b0;
  logic [15:0] i_in = '0, q_in = '0, strb_in = '0;
  logic        valid_in = 1'b0;
  logic [15:0] i_out, q_out;
  logic        valid_out, locked, strb_err;
  logic [3:0]  offset;
  int          n_cmp = 0;
  int          n_err = 0;

  adrv9001_rx_align #(.LOCK_COUNT(4), .UNLOCK_COUNT(2)) dut (
    .clk(clk), .rstn(rstn), .strb_mode(strb_mode),
    .i_in(i_in), .q_in(q_in), .strb_in(strb_in), .valid_in(valid_in),
    .i_out(i_out), .q_out(q_out), .valid_out(valid_out),
    .locked(locked), .offset(offset), .strb_err(strb_err)
  );

  always #5 clk = ~clk;

  task automatic beat(input logic [15:0] i, input logic [15:0] q, input logic [15:0] s);
    @(negedge clk);
    valid_in = 1'b1;
    i_in = i;
    q_in = q;
    strb_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic m);
    @(negedge clk);
    rstn = 1'b0;
    valid_in = 1'b0;
    strb_mode = m;
    @(posedge clk);
    #1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rstn = 1'b0;
    valid_in = 1'b1;
    strb_in = 16'h0FF0;
    i_in = 16'hFFFF;
    q_in = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({i_out, q_out, valid_out, locked, offset, strb_err} !== 40'h0) begin
      n_err++;
      $display("FAIL reset_outputs got %h exp 0", {i_out, q_out, valid_out, locked, offset, strb_err});
    end
    @(negedge clk);
    rstn = 1'b1;
    valid_in = 1'b0;
  endtask

  task automatic test_lock_mode0;
    logic [15:0] exp_i;
    do_reset(1'b0);
    for (int b = 1; b <= 7; b++) begin
      beat((b % 2) ? 16'h1234 : 16'h5678, 16'hA5A5, 16'h0FF0);
      n_cmp++;
      if (locked !== (b >= 5)) begin
        n_err++;
        $display("FAIL lock0_locked beat %0d got %b exp %b", b, locked, b >= 5);
      end
      n_cmp++;
      if (valid_out !== (b >= 6)) begin
        n_err++;
        $display("FAIL lock0_valid beat %0d got %b exp %b", b, valid_out, b >= 6);
      end
      if (b == 5) begin
        n_cmp++;
        if (offset !== 4'd4) begin
          n_err++;
          $display("FAIL lock0_offset got %0d exp 4", offset);
        end
      end
      if (b >= 6) begin
        exp_i = (b == 6) ? 16'h2345 : 16'h6781;
        n_cmp++;
        if (i_out !== exp_i || q_out !== 16'h5A5A) begin
          n_err++;
          $display("FAIL lock0_data beat %0d got %h/%h exp %h/5a5a", b, i_out, q_out, exp_i);
        end
      end
      gap(1);
      n_cmp++;
      if (valid_out !== 1'b0 || strb_err !== 1'b0) begin
        n_err++;
        $display("FAIL lock0_gap_pulse beat %0d got %b%b exp 00", b, valid_out, strb_err);
      end
    end
  endtask

  task automatic test_strb_err;
    logic [15:0] s_seq [7] = '{16'h0000, 16'h0FF0, 16'h0FF0, 16'h0000, 16'h0000, 16'h0FF0, 16'h0FF0};
    logic        e_err [7] = '{0, 1, 0, 0, 1, 1, 0};
    logic        e_lck [7] = '{1, 1, 1, 1, 1, 0, 0};
    logic        e_vld [7] = '{1, 1, 1, 1, 1, 1, 0};
    for (int b = 0; b < 7; b++) begin
      beat(16'h1234, 16'hA5A5, s_seq[b]);
      n_cmp++;
      if ({strb_err, locked, valid_out} !== {e_err[b], e_lck[b], e_vld[b]}) begin
        n_err++;
        $display("FAIL err_seq step %0d got err/lck/vld %b%b%b exp %b%b%b",
                 b, strb_err, locked, valid_out, e_err[b], e_lck[b], e_vld[b]);
      end
      if (b == 1) begin
        n_cmp++;
        if (i_out !== 16'h2341) begin
          n_err++;
          $display("FAIL err_data got %h exp 2341", i_out);
        end
      end
      gap(1);
      n_cmp++;
      if (strb_err !== 1'b0) begin
        n_err++;
        $display("FAIL err_pulse_width step %0d got %b exp 0", b, strb_err);
      end
    end
  endtask

  task automatic test_mode_change;
    do_reset(1'b0);
    for (int b = 1; b <= 5; b++) begin
      beat(16'h1234, 16'hA5A5, 16'h0FF0);
      gap(1);
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++;
      $display("FAIL mode_prelock got %b exp 1", locked);
    end
    @(negedge clk);
    strb_mode = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (locked !== 1'b0) begin
      n_err++;
      $display("FAIL mode_unlock got %b exp 0", locked);
    end
    for (int b = 1; b <= 6; b++) begin
      beat(16'h1234, 16'hA5A5, 16'h0001);
      n_cmp++;
      if (locked !== (b >= 5) || valid_out !== (b >= 6)) begin
        n_err++;
        $display("FAIL mode1_lock beat %0d got lck/vld %b%b exp %b%b", b, locked, valid_out, b >= 5, b >= 6);
      end
      if (b == 5) begin
        n_cmp++;
        if (offset !== 4'd15) begin
          n_err++;
          $display("FAIL mode1_offset got %0d exp 15", offset);
        end
      end
      if (b == 6) begin
        n_cmp++;
        if (i_out !== 16'h091A) begin
          n_err++;
          $display("FAIL mode1_data got %h exp 091a", i_out);
        end
      end
      gap(1);
    end
  endtask

  task automatic test_reset_with_valid;
    @(negedge clk);
    rstn = 1'b0;
    valid_in = 1'b1;
    strb_in = 16'h0001;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({i_out, q_out, valid_out, locked, offset, strb_err} !== 40'h0) begin
      n_err++;
      $display("FAIL rst_valid_outputs got %h exp 0", {i_out, q_out, valid_out, locked, offset, strb_err});
    end
    @(negedge clk);
    rstn = 1'b1;
    valid_in = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      beat(16'h1234, 16'hA5A5, 16'h0001);
      n_cmp++;
      if (locked !== (b == 5)) begin
        n_err++;
        $display("FAIL rst_valid_relock beat %0d got %b exp %b", b, locked, b == 5);
      end
      gap(1);
    end
  endtask

  task automatic test_gapped;
    do_reset(1'b0);
    for (int b = 1; b <= 7; b++) begin
      beat((b % 2) ? 16'h1234 : 16'h5678, 16'hA5A5, 16'h0FF0);
      n_cmp++;
      if (locked !== (b >= 5) || valid_out !== (b >= 6)) begin
        n_err++;
        $display("FAIL gap_lock beat %0d got lck/vld %b%b exp %b%b", b, locked, valid_out, b >= 5, b >= 6);
      end
      for (int g = 0; g < 3; g++) begin
        gap(1);
        n_cmp++;
        if (valid_out !== 1'b0 || strb_err !== 1'b0 || locked !== (b >= 5)) begin
          n_err++;
          $display("FAIL gap_hold beat %0d cyc %0d got vld/err/lck %b%b%b exp 00%b", b, g, valid_out, strb_err, locked, b >= 5);
        end
      end
    end
    n_cmp++;
    if (offset !== 4'd4 || i_out !== 16'h6781) begin
      n_err++;
      $display("FAIL gap_final got off %0d i %h exp 4 6781", offset, i_out);
    end
  endtask

  initial begin
    test_reset();
    test_lock_mode0();
    test_strb_err();
    test_mode_change();
    test_reset_with_valid();
    test_gapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
